// File: rtl/rx_unstuff_shifter.sv
// USB receive bit unstuffer and byte assembler. It sits after the NRZI decoder.
// It drops stuffed zeros, packs bits LSB-first and flags stuffing and alignment errors.
module rx_unstuff_shifter #(
  parameter int DATA_W    = 8,
  parameter int STUFF_LEN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              eop,
  output logic [DATA_W-1:0] rcv_data,
  output logic              byte_done,
  output logic              stuff_err,
  output logic              align_err
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int OW = $clog2(STUFF_LEN + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [OW-1:0] ONES_FULL = OW'(STUFF_LEN);

  logic [DATA_W-1:0] r_sr;
  logic [BW-1:0]     r_bit_cnt;
  logic [OW-1:0]     r_ones_cnt;

  logic [DATA_W-1:0] w_sr_next;
  logic              w_stuff_slot;
  logic              w_word_end;

  assign w_sr_next    = {d_orig, r_sr[DATA_W-1:1]};
  assign w_stuff_slot = (r_ones_cnt == ONES_FULL);
  assign w_word_end   = (r_bit_cnt == BIT_LAST);

  // Assembly state and registered status pulses; eop outranks a coincident strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sr       <= '0;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
      rcv_data   <= '0;
      byte_done  <= 1'b0;
      stuff_err  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      stuff_err <= 1'b0;
      align_err <= 1'b0;
      if (eop) begin
        align_err  <= (r_bit_cnt != '0);
        r_sr       <= '0;
        r_bit_cnt  <= '0;
        r_ones_cnt <= '0;
      end else if (shift_enable) begin
        if (w_stuff_slot) begin
          // The stuff bit itself never reaches the word; a 1 here is a violation.
          r_ones_cnt <= '0;
          stuff_err  <= d_orig;
        end else begin
          r_sr       <= w_sr_next;
          r_ones_cnt <= d_orig ? (r_ones_cnt + OW'(1)) : '0;
          if (w_word_end) begin
            r_bit_cnt <= '0;
            rcv_data  <= w_sr_next;
            byte_done <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
      end else begin
        r_sr       <= r_sr;
        r_bit_cnt  <= r_bit_cnt;
        r_ones_cnt <= r_ones_cnt;
      end
    end
  end

endmodule
